// File: rtl/int_exec_unit.sv
// Integer/branch execute stage: one-cycle ALU and branch compare, 1-bit/cycle
// iterative shifter, single-entry result register with valid/ready handshake.
module int_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_br,
    input  logic [2:0]      in_funct3,
    input  logic            in_alt,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_is_br,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {EMPTY, SHIFT, FULL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            is_br_q, is_br_d;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;

    logic            accept;
    logic [SW-1:0]   shamt;
    logic            is_shift;
    logic [XLEN-1:0] sum;
    logic            lt_s, lt_u, eq;
    logic [XLEN-1:0] int_res;
    logic            br_taken;
    logic [XLEN-1:0] shift_step;

    assign in_ready = !flush && (state_q == EMPTY || (state_q == FULL && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt    = in_b[SW-1:0];
    assign is_shift = !in_is_br && (in_funct3 == 3'b001 || in_funct3 == 3'b101);

    assign sum  = in_alt ? in_a - in_b : in_a + in_b;
    assign lt_s = $signed(in_a) < $signed(in_b);
    assign lt_u = in_a < in_b;
    assign eq   = in_a == in_b;

    // Shift ops land here only for a zero amount, where the result is just a.
    always_comb begin
        int_res = '0;
        case (in_funct3)
            3'b000: int_res = sum;
            3'b001: int_res = in_a;
            3'b010: int_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: int_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100: int_res = in_a ^ in_b;
            3'b101: int_res = in_a;
            3'b110: int_res = in_a | in_b;
            3'b111: int_res = in_a & in_b;
            default: int_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (in_funct3)
            3'b000: br_taken = eq;
            3'b001: br_taken = !eq;
            3'b100: br_taken = lt_s;
            3'b101: br_taken = !lt_s;
            3'b110: br_taken = lt_u;
            3'b111: br_taken = !lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    // Arithmetic right shift keeps the MSB, so the original sign is preserved.
    assign shift_step = left_q  ? {res_q[XLEN-2:0], 1'b0} :
                        arith_q ? {res_q[XLEN-1], res_q[XLEN-1:1]} :
                                  {1'b0, res_q[XLEN-1:1]};

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        is_br_d  = is_br_q;
        taken_d  = taken_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        arith_d  = arith_q;

        case (state_q)
            SHIFT: begin
                res_d = shift_step;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) state_d = FULL;
            end
            FULL:    if (out_ready) state_d = EMPTY;
            default: ;
        endcase

        if (accept) begin
            state_d  = (is_shift && shamt != '0) ? SHIFT : FULL;
            res_d    = in_is_br ? '0 : int_res;
            is_br_d  = in_is_br;
            taken_d  = in_is_br && br_taken;
            target_d = in_is_br ? in_pc + in_imm : '0;
            cnt_d    = shamt;
            left_d   = (in_funct3 == 3'b001);
            arith_d  = in_alt;
        end

        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            res_q    <= '0;
            is_br_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            is_br_q  <= is_br_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
        end
    end

    assign out_valid     = (state_q == FULL);
    assign busy          = (state_q != EMPTY);
    assign out_result    = res_q;
    assign out_is_br     = is_br_q;
    assign out_br_taken  = taken_q;
    assign out_br_target = target_q;

endmodule

// File: tb/tb_int_exec_unit.sv
// Directed bench for int_exec_unit: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on each output handshake.
module tb_int_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_br = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic        in_alt = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, in_pc = '0, in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_is_br;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        int          at;
    } exp_t;
    exp_t q[$];

    int_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_br(in_is_br), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_is_br(out_is_br),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got res=%h br=%b tk=%b tgt=%h at cycle %0d, want no output",
                         out_result, out_is_br, out_br_taken, out_br_target, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_result !== e.res || out_is_br !== e.br || out_br_taken !== e.tk ||
                    out_br_target !== e.tgt || (e.at >= 0 && cyc != e.at)) begin
                    bad++;
                    $display("FAIL result: got res=%h br=%b tk=%b tgt=%h cyc=%0d, want res=%h br=%b tk=%b tgt=%h cyc=%0d",
                             out_result, out_is_br, out_br_taken, out_br_target, cyc,
                             e.res, e.br, e.tk, e.tgt, e.at);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Present one op; lat < 0 disables the arrival-cycle check.
    task automatic send(input logic br, input logic [2:0] f3, input logic alt,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic push, input logic [31:0] eres,
                        input logic etk, input logic [31:0] etgt, input int lat);
        int n = 0;
        in_is_br = br; in_funct3 = f3; in_alt = alt;
        in_a = a; in_b = b; in_pc = pc; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (push) q.push_back('{eres, br, etk, etgt, (lat < 0) ? -1 : cyc + lat});
        end
    endtask

    task automatic op(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eres, input int lat);
        send(1'b0, f3, alt, a, b, 32'h0, 32'h0, 1'b1, eres, 1'b0, 32'h0, lat);
    endtask

    task automatic brn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic etk, input logic [31:0] etgt);
        send(1'b1, f3, 1'b0, a, b, pc, imm, 1'b1, 32'h0, etk, etgt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_outputs", out_result | out_br_target | {30'b0, out_is_br, out_br_taken}, 32'h0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Single-cycle ALU ops, issued back to back
        op(3'b000, 1'b0, 32'h5, 32'hFFFF_FFFD, 32'h2, 0);
        op(3'b000, 1'b1, 32'h5, 32'hFFFF_FFFD, 32'h8, 0);
        op(3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
        op(3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
        op(3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 0);
        op(3'b011, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 0);
        op(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
        op(3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);

        // Iterative shifts: in_ready low while shifting
        op(3'b101, 1'b1, 32'h8000_0000, 32'h4, 32'hF800_0000, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("shift_in_ready_low", {31'b0, in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        op(3'b101, 1'b0, 32'h8000_0000, 32'h4, 32'h0800_0000, 4);
        op(3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h8000_0000, 0);
        op(3'b001, 1'b0, 32'h1, 32'h1F, 32'h8000_0000, 31);
        op(3'b101, 1'b1, 32'h8000_0001, 32'h25, 32'hFC00_0000, 5);
        op(3'b001, 1'b0, 32'h1234_5678, 32'h4, 32'h2345_6780, 4);

        // Branches (including BNE with a shift-like funct3 and the 010 encoding)
        brn(3'b100, 32'hFFFF_FFFE, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b1, 32'hF0);
        brn(3'b101, 32'hFFFF_FFFE, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b0, 32'hF0);
        brn(3'b111, 32'hFFFF_FFFE, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b1, 32'hF0);
        brn(3'b110, 32'hFFFF_FFFE, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b0, 32'hF0);
        brn(3'b000, 32'h1234, 32'h1234, 32'h200, 32'h8, 1'b1, 32'h208);
        brn(3'b001, 32'h1234, 32'h1234, 32'h200, 32'h8, 1'b0, 32'h208);
        brn(3'b001, 32'h1, 32'h4, 32'h200, 32'h8, 1'b1, 32'h208);
        brn(3'b010, 32'h1, 32'h2, 32'h300, 32'h10, 1'b0, 32'h310);

        // Back-pressure: result held stable, then released with a new op
        @(posedge clk); #1;
        out_ready = 1'b0;
        op(3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'b0, out_valid}, 32'h1);
            chk("hold_out_result", out_result, 32'h0FF0_0FF0);
            chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        op(3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 0);

        // Flush during a long shift
        send(1'b0, 3'b001, 1'b0, 32'h1, 32'd20, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", {31'b0, seen}, 32'h0);

        // Asynchronous reset in the middle of a shift
        @(posedge clk); #1;
        send(1'b0, 3'b001, 1'b0, 32'h1, 32'd10, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midshift_rst_valid_busy", {30'b0, out_valid, busy}, 32'h0);
        chk("midshift_rst_result", out_result, 32'h0);
        chk("midshift_rst_br", out_br_target | {30'b0, out_is_br, out_br_taken}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_valid", {31'b0, seen}, 32'h0);
        @(posedge clk); #1;
        op(3'b000, 1'b0, 32'h7, 32'h9, 32'h10, 0);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
